// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the CORDIC pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Provides the mode enum, default widths, the arctan table function and the gain constant function.
package cordic_pkg;

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } mode_e;

    localparam int DEF_WORD_WIDTH = 20;
    localparam int DEF_FRAC_WIDTH = 15;
    localparam int DEF_N_STEPS    = 16;
    localparam int DEF_TAG_WIDTH  = 4;

    // arctan(1/n) in Q60 from the alternating Taylor series; only used with n >= 2,
    // where 40 terms are far more than enough.
    function automatic longint atan_inv_q60(input longint n);
        longint acc;
        longint p;
        acc = 0;
        p   = (longint'(1) <<< 60) / n;
        for (longint k = 0; k < 40; k++) begin
            if (k[0] == 1'b0)
                acc = acc + p / (longint'(2) * k + longint'(1));
            else
                acc = acc - p / (longint'(2) * k + longint'(1));
            p = p / n;
            p = p / n;
        end
        return acc;
    endfunction

    // atan(2^-i) rounded to nearest with 'frac' fractional bits.
    // atan(1) comes from Machin's formula because the plain series at 1 converges too slowly.
    function automatic longint atan_q(input int i, input int frac);
        longint a;
        if (i == 0)
            a = longint'(4) * atan_inv_q60(5) - atan_inv_q60(239);
        else
            a = atan_inv_q60(longint'(1) <<< i);
        return (a + (longint'(1) <<< (59 - frac))) >>> (60 - frac);
    endfunction

    // K = 1/sqrt(prod(1 + 4^-i)) rounded to 'frac' fractional bits.
    // The product is built by shift-and-add in Q60, then 1/sqrt by Newton iteration in Q30.
    function automatic longint gain_q(input int n_steps, input int frac);
        longint p;
        longint y;
        longint t;
        p = longint'(1) <<< 60;
        for (int i = 0; i < n_steps; i++)
            p = p + (p >>> (2 * i));
        p = p >>> 30;
        y = longint'(644245094);            // 0.6 in Q30, close to the final K
        for (int it = 0; it < 24; it++) begin
            t = (y * y) >>> 30;
            t = (t * p) >>> 30;
            y = (y * ((longint'(3) <<< 30) - t)) >>> 31;
        end
        return (y + (longint'(1) <<< (29 - frac))) >>> (30 - frac);
    endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// One CORDIC micro-rotation by 2^-STAGE with registered outputs.
// Latency: 1 cycle. Backpressure: holds all registers while en=0.
// Ports: en (global advance), vld/mode/tag/x/y/z in and out; x/y carry 2 guard MSBs.
module cordic_pipe_stage
    import cordic_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int STAGE      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         vld_i,
    input  mode_e                        mode_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    input  logic signed [WORD_WIDTH+1:0] x_i,
    input  logic signed [WORD_WIDTH+1:0] y_i,
    input  logic signed [WORD_WIDTH-1:0] z_i,
    output logic                         vld_o,
    output mode_e                        mode_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
    output logic signed [WORD_WIDTH+1:0] x_o,
    output logic signed [WORD_WIDTH+1:0] y_o,
    output logic signed [WORD_WIDTH-1:0] z_o
);

    localparam logic signed [WORD_WIDTH-1:0] ATAN = WORD_WIDTH'(atan_q(STAGE, FRAC_WIDTH));

    logic                         d_pos;
    logic signed [WORD_WIDTH+1:0] x_sh;
    logic signed [WORD_WIDTH+1:0] y_sh;
    logic signed [WORD_WIDTH+1:0] x_nx;
    logic signed [WORD_WIDTH+1:0] y_nx;
    logic signed [WORD_WIDTH-1:0] z_nx;

    always_comb begin
        // d=+1 rotates counter-clockwise: chosen to drive z to 0 (rotation)
        // or y to 0 (vectoring), using this sample's own mode.
        d_pos = (mode_i == ROTATION) ? ~z_i[WORD_WIDTH-1] : y_i[WORD_WIDTH+1];
        x_sh  = x_i >>> STAGE;
        y_sh  = y_i >>> STAGE;
        if (d_pos) begin
            x_nx = x_i - y_sh;
            y_nx = y_i + x_sh;
            z_nx = z_i - ATAN;
        end else begin
            x_nx = x_i + y_sh;
            y_nx = y_i - x_sh;
            z_nx = z_i + ATAN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_o  <= 1'b0;
            mode_o <= ROTATION;
            tag_o  <= '0;
            x_o    <= '0;
            y_o    <= '0;
            z_o    <= '0;
        end else if (en) begin
            vld_o  <= vld_i;
            mode_o <= mode_i;
            tag_o  <= tag_i;
            x_o    <= x_nx;
            y_o    <= y_nx;
            z_o    <= z_nx;
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// Pipelined CORDIC (rotation/vectoring per sample) with gain compensation and saturation.
// Latency: N_STEPS+1 cycles. Backpressure: whole pipe stalls when vld_o=1 and rdy_i=0; rdy_o follows.
// Ports: x/y/z/mode/tag in with vld_i/rdy_o; x/y/z/mode/tag/ovf out with vld_o/rdy_i.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int N_STEPS    = DEF_N_STEPS,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] x_i,
    input  logic [WORD_WIDTH-1:0] y_i,
    input  logic [WORD_WIDTH-1:0] z_i,
    input  logic                  mode_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    output logic [WORD_WIDTH-1:0] x_o,
    output logic [WORD_WIDTH-1:0] y_o,
    output logic [WORD_WIDTH-1:0] z_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  mode_o,
    output logic                  ovf_o,
    output logic                  vld_o,
    input  logic                  rdy_i
);

    localparam int GW = WORD_WIDTH + 2;               // guard bits absorb the ~1.65 CORDIC gain
    localparam int PW = GW + FRAC_WIDTH + 2;          // full product width for the gain multiply

    localparam logic signed [FRAC_WIDTH+1:0] K =
        (FRAC_WIDTH+2)'(gain_q(N_STEPS, FRAC_WIDTH));
    localparam logic signed [PW-1:0] HALF    = PW'(1) <<< (FRAC_WIDTH - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};

    logic                         en;
    logic                         vld_s  [0:N_STEPS];
    mode_e                        mode_s [0:N_STEPS];
    logic [TAG_WIDTH-1:0]         tag_s  [0:N_STEPS];
    logic signed [GW-1:0]         x_s    [0:N_STEPS];
    logic signed [GW-1:0]         y_s    [0:N_STEPS];
    logic signed [WORD_WIDTH-1:0] z_s    [0:N_STEPS];

    // One global enable: the only place a sample can wait is the output register,
    // so every stage moves together whenever that register is empty or draining.
    assign en    = ~vld_o | rdy_i;
    assign rdy_o = en & ~rst;

    assign vld_s[0]  = vld_i;
    assign mode_s[0] = mode_e'(mode_i);
    assign tag_s[0]  = tag_i;
    assign x_s[0]    = {{2{x_i[WORD_WIDTH-1]}}, x_i};
    assign y_s[0]    = {{2{y_i[WORD_WIDTH-1]}}, y_i};
    assign z_s[0]    = z_i;

    for (genvar s = 0; s < N_STEPS; s++) begin : g_stage
        cordic_pipe_stage #(
            .WORD_WIDTH (WORD_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .STAGE      (s)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .vld_i  (vld_s[s]),
            .mode_i (mode_s[s]),
            .tag_i  (tag_s[s]),
            .x_i    (x_s[s]),
            .y_i    (y_s[s]),
            .z_i    (z_s[s]),
            .vld_o  (vld_s[s+1]),
            .mode_o (mode_s[s+1]),
            .tag_o  (tag_s[s+1]),
            .x_o    (x_s[s+1]),
            .y_o    (y_s[s+1]),
            .z_o    (z_s[s+1])
        );
    end

    // Returns {saturated, value} clipped to the output word range.
    function automatic logic [WORD_WIDTH:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[WORD_WIDTH-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[WORD_WIDTH-1:0]};
        else
            return {1'b0, v[WORD_WIDTH-1:0]};
    endfunction

    logic signed [PW-1:0]  px;
    logic signed [PW-1:0]  py;
    logic signed [PW-1:0]  rx;
    logic signed [PW-1:0]  ry;
    logic                  ovf_x;
    logic                  ovf_y;
    logic [WORD_WIDTH-1:0] sx;
    logic [WORD_WIDTH-1:0] sy;

    always_comb begin
        px = PW'(x_s[N_STEPS]) * PW'(K);
        py = PW'(y_s[N_STEPS]) * PW'(K);
        rx = (px + HALF) >>> FRAC_WIDTH;              // round half up to nearest
        ry = (py + HALF) >>> FRAC_WIDTH;
        {ovf_x, sx} = sat(rx);
        {ovf_y, sy} = sat(ry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_o  <= 1'b0;
            ovf_o  <= 1'b0;
            x_o    <= '0;
            y_o    <= '0;
            z_o    <= '0;
            tag_o  <= '0;
            mode_o <= 1'b0;
        end else if (en) begin
            vld_o  <= vld_s[N_STEPS];
            ovf_o  <= vld_s[N_STEPS] & (ovf_x | ovf_y);
            x_o    <= sx;
            y_o    <= sy;
            z_o    <= z_s[N_STEPS];                   // angle wraps, never saturates
            tag_o  <= tag_s[N_STEPS];
            mode_o <= mode_s[N_STEPS];
        end
    end

endmodule
